// File: rtl/count_ramp_monitor.sv
// Consumer-side checker for a saturating ramp counter (0 -> LIMIT, then hold).
// Tracks ramp phase, flags the limit, counts hold samples and latches the first illegal step.
module count_ramp_monitor #(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned LIMIT  = 200,
    parameter int unsigned HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              cnt_valid,
    input  logic              clr_viol,
    output logic [1:0]        state,
    output logic              reached,
    output logic [HOLD_W-1:0] hold_cycles,
    output logic              viol,
    output logic [1:0]        viol_code,
    output logic [WIDTH-1:0]  viol_value
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        V_NONE = 2'd0,
        V_OVER = 2'd1,
        V_SKIP = 2'd2,
        V_DROP = 2'd3
    } vcode_t;

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    state_t              st_q, st_d;
    vcode_t              code_q, code_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                viol_q, viol_d;
    logic [WIDTH-1:0]    val_q, val_d;
    logic                reached_q, reached_d;
    logic [WIDTH:0]      step;

    // One extra bit so prev+1 can never wrap back onto a small cnt_in.
    assign step = {1'b0, prev_q} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        st_d      = st_q;
        code_d    = code_q;
        prev_d    = prev_q;
        hold_d    = hold_q;
        viol_d    = viol_q;
        val_d     = val_q;
        reached_d = 1'b0;

        if (st_q == FAULT) begin
            if (clr_viol) begin
                st_d   = IDLE;
                code_d = V_NONE;
                prev_d = '0;
                hold_d = '0;
                viol_d = 1'b0;
                val_d  = '0;
            end
        end else if (cnt_valid) begin
            if (cnt_in > LIM) begin
                st_d   = FAULT;
                viol_d = 1'b1;
                code_d = V_OVER;
                val_d  = cnt_in;
            end else if (cnt_in == '0) begin
                st_d   = RAMP;
                prev_d = '0;
                hold_d = '0;
            end else begin
                unique case (st_q)
                    IDLE: begin
                        prev_d = cnt_in;
                        if (cnt_in == LIM) begin
                            st_d      = HOLD;
                            reached_d = 1'b1;
                        end else begin
                            st_d = RAMP;
                        end
                    end
                    RAMP: begin
                        if ({1'b0, cnt_in} == step) begin
                            prev_d = cnt_in;
                            if (cnt_in == LIM) begin
                                st_d      = HOLD;
                                reached_d = 1'b1;
                            end
                        end else begin
                            st_d   = FAULT;
                            viol_d = 1'b1;
                            code_d = V_SKIP;
                            val_d  = cnt_in;
                        end
                    end
                    HOLD: begin
                        if (cnt_in == LIM) begin
                            if (hold_q != '1) begin
                                hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            st_d   = FAULT;
                            viol_d = 1'b1;
                            code_d = V_DROP;
                            val_d  = cnt_in;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= IDLE;
            code_q    <= V_NONE;
            prev_q    <= '0;
            hold_q    <= '0;
            viol_q    <= 1'b0;
            val_q     <= '0;
            reached_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            code_q    <= code_d;
            prev_q    <= prev_d;
            hold_q    <= hold_d;
            viol_q    <= viol_d;
            val_q     <= val_d;
            reached_q <= reached_d;
        end
    end

    assign state       = st_q;
    assign reached     = reached_q;
    assign hold_cycles = hold_q;
    assign viol        = viol_q;
    assign viol_code   = code_q;
    assign viol_value  = val_q;

endmodule

// File: tb/tb_count_ramp_monitor.sv
// Scoreboard bench: directed vectors push expected outputs; a monitor pops and compares each cycle.
module tb_count_ramp_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] cnt_in = '0;
    logic        cnt_valid = 1'b0;
    logic        clr_viol = 1'b0;

    logic [1:0]  state, state4;
    logic        reached, reached4;
    logic [15:0] hold_cycles;
    logic [3:0]  hold_cycles4;
    logic        viol, viol4;
    logic [1:0]  viol_code, viol_code4;
    logic [10:0] viol_value, viol_value4;

    always #5 clk = ~clk;

    count_ramp_monitor #(.WIDTH(11), .LIMIT(200), .HOLD_W(16)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clr_viol(clr_viol),
        .state(state), .reached(reached), .hold_cycles(hold_cycles),
        .viol(viol), .viol_code(viol_code), .viol_value(viol_value)
    );

    // Narrow hold counter build, fed the same stimulus, to exercise saturation.
    count_ramp_monitor #(.WIDTH(11), .LIMIT(200), .HOLD_W(4)) dut4 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clr_viol(clr_viol),
        .state(state4), .reached(reached4), .hold_cycles(hold_cycles4),
        .viol(viol4), .viol_code(viol_code4), .viol_value(viol_value4)
    );

    typedef struct {
        logic [1:0]  st;
        logic        rch;
        logic [15:0] hc;
        logic [3:0]  hc4;
        logic        vi;
        logic [1:0]  code;
        logic [10:0] val;
    } exp_t;

    exp_t q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
        if (act !== exv) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %0d expected %0d", nm, vectors, act, exv);
        end
    endtask

    task automatic vec(input logic r, input logic v, input logic [10:0] c, input logic cl,
                       input logic [1:0] st, input logic rch, input logic [15:0] hc,
                       input logic vi, input logic [1:0] code, input logic [10:0] val);
        exp_t e;
        @(negedge clk);
        rst = r; cnt_valid = v; cnt_in = c; clr_viol = cl;
        e.st = st; e.rch = rch; e.hc = hc; e.hc4 = (hc > 16'd15) ? 4'd15 : hc[3:0];
        e.vi = vi; e.code = code; e.val = val;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                chk("state",        32'(state),        32'(e.st));
                chk("reached",      32'(reached),      32'(e.rch));
                chk("hold_cycles",  32'(hold_cycles),  32'(e.hc));
                chk("viol",         32'(viol),         32'(e.vi));
                chk("viol_code",    32'(viol_code),    32'(e.code));
                chk("viol_value",   32'(viol_value),   32'(e.val));
                chk("state4",       32'(state4),       32'(e.st));
                chk("reached4",     32'(reached4),     32'(e.rch));
                chk("hold_cycles4", 32'(hold_cycles4), 32'(e.hc4));
                chk("viol4",        32'(viol4),        32'(e.vi));
                chk("viol_code4",   32'(viol_code4),   32'(e.code));
                chk("viol_value4",  32'(viol_value4),  32'(e.val));
            end
        end
    end

    initial begin : stimulus
        int unsigned waited;
        // Reset values
        vec(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        vec(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);

        // Full ramp to the limit, reached pulse, 5 hold samples, gap in HOLD
        vec(0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 199; i++) vec(0, 1, 11'(i), 0,   1, 0, 0, 0, 0, 0);
        vec(0, 1, 200, 0,  2, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) vec(0, 1, 200, 0,   2, 0, 16'(k), 0, 0, 0);
        vec(0, 0, 200, 0,  2, 0, 5, 0, 0, 0);

        // Restart from HOLD with 0
        vec(0, 1, 0, 0,    1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 199; i++) vec(0, 1, 11'(i), 0,   1, 0, 0, 0, 0, 0);
        vec(0, 1, 200, 0,  2, 1, 0, 0, 0, 0);
        // 20 hold samples: 16-bit counter reaches 20, 4-bit saturates at 15
        for (int k = 1; k <= 20; k++) vec(0, 1, 200, 0,   2, 0, 16'(k), 0, 0, 0);
        // Drop in HOLD, then FAULT ignores samples
        vec(0, 1, 150, 0,  3, 0, 20, 1, 3, 150);
        vec(0, 1, 13, 0,   3, 0, 20, 1, 3, 150);

        // Clear wins over a simultaneous sample
        vec(0, 1, 0, 1,    0, 0, 0, 0, 0, 0);
        vec(0, 1, 0, 0,    1, 0, 0, 0, 0, 0);

        // Skip 0..10 -> 12
        for (int i = 1; i <= 10; i++) vec(0, 1, 11'(i), 0,   1, 0, 0, 0, 0, 0);
        vec(0, 1, 12, 0,   3, 0, 0, 1, 2, 12);
        vec(0, 1, 13, 0,   3, 0, 0, 1, 2, 12);
        vec(0, 1, 14, 0,   3, 0, 0, 1, 2, 12);
        vec(0, 0, 14, 0,   3, 0, 0, 1, 2, 12);
        vec(0, 0, 0, 1,    0, 0, 0, 0, 0, 0);

        // Gaps are legal; IDLE accepts a mid-ramp value
        vec(0, 1, 5, 0,    1, 0, 0, 0, 0, 0);
        for (int g = 0; g < 3; g++) vec(0, 0, 99, 0,   1, 0, 0, 0, 0, 0);
        vec(0, 1, 6, 0,    1, 0, 0, 0, 0, 0);
        for (int i = 7; i <= 99; i++) vec(0, 1, 11'(i), 0,   1, 0, 0, 0, 0, 0);
        // rst mid-ramp overrides the sample
        vec(1, 1, 100, 0,  0, 0, 0, 0, 0, 0);

        // First sample over the limit
        vec(0, 1, 201, 0,  3, 0, 0, 1, 1, 201);
        // rst overrides FAULT even with clr and a sample present
        vec(1, 1, 5, 1,    0, 0, 0, 0, 0, 0);
        // clr outside FAULT has no effect
        vec(0, 1, 0, 1,    1, 0, 0, 0, 0, 0);
        vec(1, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        // IDLE straight to HOLD, then overshoot from HOLD takes OVER priority
        vec(0, 1, 200, 0,  2, 1, 0, 0, 0, 0);
        vec(0, 1, 201, 0,  3, 0, 0, 1, 1, 201);
        vec(1, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        // Repeated value in RAMP is a skip
        vec(0, 1, 0, 0,    1, 0, 0, 0, 0, 0);
        vec(0, 1, 1, 0,    1, 0, 0, 0, 0, 0);
        vec(0, 1, 2, 0,    1, 0, 0, 0, 0, 0);
        vec(0, 1, 2, 0,    3, 0, 0, 1, 2, 2);
        vec(0, 0, 0, 0,    3, 0, 0, 1, 2, 2);

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
